// File: rtl/apb2_cmd_master.sv
// APB2 initiator: accepts one command at a time from fabric logic, runs the APB2
// SETUP/ACCESS sequence with wait-state and timeout handling, and returns a valid/ready response.
module apb2_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  output logic [2:0]            pprot,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // cmd_ready resets low, so acceptance is only possible from the second edge after reset
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          paddr_d     = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
          pwrite_d    = cmd_write;
          pprot_d     = cmd_prot;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pstrb_d     = cmd_write ? cmd_strb : '0;
          state_d     = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = CNT_ONE;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        // pready has priority over a coincident timeout
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (TO_EN && (cnt_q == CNT_LIM)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb2_cmd_master.sv
// Directed bench for apb2_cmd_master: one instance with a 4-cycle timeout,
// one with the timeout disabled.
module tb_apb2_cmd_master;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        cmd_valid, cmd_write, rsp_ready;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata, prdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        pready, pslverr;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, pwdata;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  logic        cmd_valid0, rsp_ready0, pready0;
  logic        cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0;
  logic [31:0] rsp_rdata0, pwdata0;
  logic        psel0, penable0, pwrite0;
  logic [7:0]  paddr0;
  logic [3:0]  pstrb0;
  logic [2:0]  pprot0;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb2_cmd_master #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb2_cmd_master #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0),
    .psel(psel0), .penable(penable0), .pwrite(pwrite0), .paddr(paddr0),
    .pwdata(pwdata0), .pstrb(pstrb0), .pprot(pprot0),
    .prdata(prdata), .pready(pready0), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    int hi;
    int n;
    int early;

    preset_n   = 1'b0;
    cmd_valid  = 1'b0; cmd_write = 1'b0; rsp_ready = 1'b0;
    cmd_addr   = '0;   cmd_wdata = '0;   cmd_strb  = '0; cmd_prot = '0;
    prdata     = '0;   pready    = 1'b0; pslverr   = 1'b0;
    cmd_valid0 = 1'b0; rsp_ready0 = 1'b0; pready0 = 1'b0;

    // Reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp_err", rsp_err, 0);
    preset_n = 1'b1;
    #1;
    chk("rel_cmd_ready_pre_edge", cmd_ready, 0);
    step();
    chk("rel_cmd_ready_post_edge", cmd_ready, 1);

    // Zero-wait write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h0C; cmd_wdata = 32'h0000_00A5;
    cmd_strb = 4'hF; cmd_prot = 3'b010; pready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_penable", penable, 0);
    chk("wr_setup_cmd_ready", cmd_ready, 0);
    chk("wr_paddr", paddr, 32'h0C);
    chk("wr_pwdata", pwdata, 32'hA5);
    chk("wr_pstrb", pstrb, 4'hF);
    chk("wr_pwrite", pwrite, 1);
    chk("wr_pprot", pprot, 3'b010);
    step();
    chk("wr_access_psel", psel, 1);
    chk("wr_access_penable", penable, 1);
    chk("wr_access_rsp_valid", rsp_valid, 0);
    step();
    chk("wr_done_psel", psel, 0);
    chk("wr_done_penable", penable, 0);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_hs_rsp_valid", rsp_valid, 0);
    chk("wr_hs_cmd_ready", cmd_ready, 1);
    chk("wr_idle_paddr_hold", paddr, 32'h0C);

    // Read with 3 wait states; prdata/pslverr noise during waits must be ignored
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h13; cmd_wdata = 32'h1234_5678;
    cmd_strb = 4'hF; cmd_prot = 3'b001; pready = 1'b0; prdata = 32'h1111_1111; pslverr = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("rd_paddr", paddr, 32'h10);
    chk("rd_pstrb", pstrb, 0);
    chk("rd_pwdata", pwdata, 0);
    chk("rd_pwrite", pwrite, 0);
    step();
    chk("rd_penable", penable, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_wait_rsp_valid", rsp_valid, 0);
      chk("rd_wait_penable", penable, 1);
    end
    pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b0;
    step();
    pready = 1'b0; prdata = 32'h2222_2222;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", rsp_err, 0);

    // Back-pressure: response held, no new command accepted
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h44;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_psel", psel, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_hs_rsp_valid", rsp_valid, 0);
    chk("bp_hs_cmd_ready", cmd_ready, 1);
    chk("bp_hs_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // Slave error on a write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'h0000_0055;
    pready = 1'b1; pslverr = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    pslverr = 1'b0;
    chk("se_rsp_valid", rsp_valid, 1);
    chk("se_rsp_err", rsp_err, 1);
    chk("se_rsp_timeout", rsp_timeout, 0);
    chk("se_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    step();
    chk("se_hs_cmd_ready", cmd_ready, 1);

    // Back-to-back commands with rsp_ready held high: 4-cycle period
    cmd_valid = 1'b1; cmd_addr = 8'h40; pready = 1'b1;
    step();
    chk("b2b_a_psel", psel, 1);
    step();
    chk("b2b_a_penable", penable, 1);
    step();
    chk("b2b_a_rsp_valid", rsp_valid, 1);
    step();
    chk("b2b_a_hs_psel", psel, 0);
    chk("b2b_a_hs_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("b2b_b_psel", psel, 1);
    chk("b2b_b_penable", penable, 0);
    chk("b2b_b_cmd_ready", cmd_ready, 0);
    step();
    step();
    chk("b2b_b_rsp_valid", rsp_valid, 1);
    step();
    chk("b2b_b_hs_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b0;

    // Timeout with TIMEOUT_CYCLES=4
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; pready = 1'b0;
    prdata = 32'hCAFE_F00D; pslverr = 1'b1;
    step();
    cmd_valid = 1'b0;
    hi = psel ? 1 : 0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
      if (psel) hi++;
    end
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_psel_cycles", hi, 5);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_penable", penable, 0);
    pslverr = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("to_hs_cmd_ready", cmd_ready, 1);

    // pready arrives in the same cycle the counter reaches the limit
    cmd_valid = 1'b1; cmd_addr = 8'h34; pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    chk("tie_pre_rsp_valid", rsp_valid, 0);
    chk("tie_pre_psel", psel, 1);
    pready = 1'b1; prdata = 32'h5A5A_1234;
    step();
    pready = 1'b0;
    chk("tie_rsp_valid", rsp_valid, 1);
    chk("tie_rsp_timeout", rsp_timeout, 0);
    chk("tie_rsp_err", rsp_err, 0);
    chk("tie_rsp_rdata", rsp_rdata, 32'h5A5A_1234);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // TIMEOUT_CYCLES=0: waits indefinitely for pready
    cmd_valid0 = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h50; prdata = 32'h0BAD_F00D;
    step();
    cmd_valid0 = 1'b0;
    early = 0;
    repeat (1000) begin
      step();
      if (rsp_valid0) early++;
    end
    chk("t0_no_early_rsp", early, 0);
    chk("t0_psel_held", psel0, 1);
    chk("t0_penable_held", penable0, 1);
    pready0 = 1'b1;
    step();
    pready0 = 1'b0;
    chk("t0_rsp_valid", rsp_valid0, 1);
    chk("t0_rsp_timeout", rsp_timeout0, 0);
    chk("t0_rsp_err", rsp_err0, 0);
    chk("t0_rsp_rdata", rsp_rdata0, 32'h0BAD_F00D);
    rsp_ready0 = 1'b1;
    step();
    rsp_ready0 = 1'b0;
    chk("t0_hs_cmd_ready", cmd_ready0, 1);

    // Reset during ACCESS wait states
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h60; cmd_wdata = 32'h0000_0077;
    cmd_strb = 4'h3; pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("mr_pre_penable", penable, 1);
    #2;
    preset_n = 1'b0;
    #1;
    chk("mr_psel", psel, 0);
    chk("mr_penable", penable, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_cmd_ready", cmd_ready, 0);
    chk("mr_paddr", paddr, 0);
    chk("mr_pwdata", pwdata, 0);
    chk("mr_pwrite", pwrite, 0);
    chk("mr_pstrb", pstrb, 0);
    chk("mr_rsp_rdata", rsp_rdata, 0);
    #2;
    preset_n = 1'b1;
    chk("mr_rel_cmd_ready_pre", cmd_ready, 0);
    step();
    chk("mr_rel_cmd_ready", cmd_ready, 1);
    chk("mr_rel_psel", psel, 0);
    chk("mr_rel_rsp_valid", rsp_valid, 0);
    pready = 1'b1;
    repeat (3) step();
    pready = 1'b0;
    chk("mr_no_stale_rsp", rsp_valid, 0);
    chk("mr_idle_cmd_ready", cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb2_cmd_master.md
# apb2_cmd_master

APB2 initiator that turns single-command requests from fabric logic into APB2 read/write transfers toward APB2 peripherals such as the BLDC controller peripheral. It lets FPGA-side logic (a debug UART bridge, a self-test sequencer) drive the same peripheral register map the EMPU master normally drives. The block adds wait-state handling, a bounded-wait timeout and a valid/ready response channel. It works on the APB clock domain.

## Interface
- ADDR_WIDTH, 8, width of paddr and cmd_addr
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without pready before the block aborts; 0 disables the timeout
- pclk  in  1  APB clock; all logic is on the rising edge
- preset_n  in  1  reset; asynchronous assert, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  32  write data
- cmd_strb  in  4  write byte strobes
- cmd_prot  in  3  protection attributes, passed through
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  32  read data; 0 for writes and for timeouts
- rsp_err  out  1  pslverr captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel, penable, pwrite  out  1 each  APB2 control signals
- paddr  out  ADDR_WIDTH  APB2 address
- pwdata  out  32  APB2 write data
- pstrb  out  4  APB2 byte strobes
- pprot  out  3  APB2 protection attributes
- prdata  in  32  APB2 read data
- pready  in  1  APB2 ready
- pslverr  in  1  APB2 slave error

## Operation
- The state machine has four states: IDLE, SETUP, ACCESS and RESP. Every output is a register.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch the command and go to SETUP. In the same edge:
    - cmd_ready←0, psel←1, penable←0.
    - paddr←{cmd_addr[ADDR_WIDTH-1:2],2'b00}.
    - pwrite←cmd_write, pprot←cmd_prot.
    - pwdata←cmd_write?cmd_wdata:0 and pstrb←cmd_write?cmd_strb:0. Reads always drive pstrb=0.
- **SETUP**
  - Lasts exactly one cycle.
  - Set penable←1, clear the wait counter to 1, then go to ACCESS.
- **ACCESS**
  - If pready=1:
    - rsp_rdata←pwrite?0:prdata, rsp_err←pslverr, rsp_timeout←0.
    - psel←0, penable←0, rsp_valid←1, then go to RESP.
  - Else if TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES:
    - Abort with rsp_rdata←0, rsp_err←1, rsp_timeout←1.
    - psel←0, penable←0, rsp_valid←1, then go to RESP.
  - Otherwise the counter increments. The counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1, and it saturates rather than wrapping.
- **RESP**
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid←0, cmd_ready←1, then go to IDLE.
  - rsp_* hold their values afterwards until the next response.
- paddr, pwrite, pwdata, pstrb and pprot are stable from SETUP through the end of ACCESS. They hold their last values while idle.
- pslverr and prdata are sampled only in the cycle where psel&&penable&&pready. They are ignored at all other times.
- If pready and the timeout condition occur in the same cycle, pready wins: a normal completion is reported.
- Exactly one transfer is outstanding at a time. A new command is not accepted until the response has been consumed.

## Timing
- Reset value of every output is 0, including cmd_ready. cmd_ready rises on the first pclk edge after preset_n deasserts.
- Asserting preset_n mid-transfer immediately drops psel, penable and rsp_valid. The state returns to IDLE and no response is produced for the aborted command.
- Cycle sequence, counted from acceptance edge N:
  - psel=1 during cycle N+1 (SETUP).
  - penable=1 from cycle N+2 (ACCESS).
  - With pready=1 at the N+2 edge, rsp_valid=1 in cycle N+3.
- Minimum latency from command to response is 3 cycles. Minimum period per command, with rsp_ready held at 1, is 4 cycles.
- Each low-pready cycle in ACCESS adds one cycle of latency.
- On timeout, psel is high for exactly 1+TIMEOUT_CYCLES cycles: 1 SETUP cycle plus TIMEOUT_CYCLES ACCESS cycles.

## Test plan
- **Zero-wait write:** write 0x0000_00A5 to addr 0x0C, strb 0xF, pready=1 → psel high 2 cycles, penable high 1 cycle, paddr=0x0C, pwdata=0xA5; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- **Read with 3 wait states:** read addr 0x13, pready low for 3 ACCESS cycles, then prdata=0xDEADBEEF → paddr=0x10, pstrb=0, pwdata=0; rsp_rdata=0xDEADBEEF at N+6.
- **Slave error:** write with pslverr=1 together with pready=1 → rsp_err=1, rsp_timeout=0.
- **Timeout:** TIMEOUT_CYCLES=4, pready held 0 → psel high 5 cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. A repeat run with TIMEOUT_CYCLES=0 must wait until pready asserts, checked up to 1000 cycles.
- **Response back-pressure:** rsp_ready=0 for 10 cycles → rsp_* held stable and cmd_ready=0 throughout; cmd_ready=1 the cycle after the handshake; back-to-back commands achieve a 4-cycle period.
- **Reset mid-ACCESS:** assert preset_n low during wait states → all outputs 0 asynchronously; after release, cmd_ready=1 after one edge and no stale rsp_valid.
